booth_divider: RTL
==================

Name: booth_divider

Overview:
- Sequential signed divider; the inverse datapath to the 8x8->16 radix-4 Booth multiplier.
- Takes a 2W-bit signed dividend (e.g. a multiplier product) and a W-bit signed divisor.
- Returns a W-bit signed quotient and a W-bit signed remainder.
- Uses a magnitude shift-subtract core (one quotient bit per cycle) with a start/busy/done handshake and fixed latency.

Parameters:
W, 8, divisor/quotient/remainder width; dividend width is 2W.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  2W  signed two's-complement dividend, sampled with start
divisor  input  W  signed two's-complement divisor, sampled with start
quotient  output  W  signed quotient, truncated toward zero; saturated on overflow
remainder  output  W  signed remainder, sign follows dividend (zero remainder is 0)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results valid from this cycle on
div_by_zero  output  1  set with done when the sampled divisor == 0
overflow  output  1  set with done when the true quotient is outside [-2^(W-1), 2^(W-1)-1]

Behaviour:
- Reset (async, rst_n low): state=IDLE; quotient, remainder, busy, done, div_by_zero, overflow = 0; internal counter and registers = 0.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - On an edge with start=1, latch sign_n=dividend[2W-1] and sign_d=divisor[W-1].
  - Latch |dividend| as 2W-bit unsigned. -2^(2W-1) maps to 2^(2W-1), with no wrap.
  - Latch |divisor| as W-bit unsigned. -2^(W-1) maps to 2^(W-1).
  - Latch dz=(divisor==0). Clear partial remainder (W+1 bits) and the 2W-bit quotient register. Set count=0, busy=1, go to ITER.
- ITER, one step per edge for 2W edges:
  - Shift {partial remainder, quotient register} left by 1, bringing in the next dividend MSB.
  - If the shifted remainder >= |divisor|, subtract |divisor| and set the quotient LSB to 1; otherwise set it to 0.
  - Increment count. After the step with count==2W-1, go to FIX.
- FIX, one edge:
  - qmag = 2W-bit unsigned quotient; rmag = partial remainder (< |divisor| <= 2^(W-1)).
  - q_signed = (sign_n^sign_d) ? -qmag : qmag, evaluated in 2W+1 bits.
  - overflow = !dz && (q_signed > 2^(W-1)-1 || q_signed < -2^(W-1)).
  - On overflow, quotient saturates to 2^(W-1)-1 (positive) or -2^(W-1) (negative). Otherwise quotient = q_signed[W-1:0].
  - remainder = sign_n ? -rmag : rmag, truncated to W bits; always representable.
  - If dz: quotient=0, remainder=0, overflow=0, div_by_zero=1. Otherwise div_by_zero=0.
  - Set done=1, busy=0, go to IDLE.
- Latency: start sampled at edge E; results, flags and done update at edge E+2W+1 (E+17 for W=8). This latency is fixed for every operand, including divide-by-zero.
- done is high for exactly one cycle and clears on the next edge.
- quotient, remainder, div_by_zero and overflow hold until the next done.
- start while busy (ITER/FIX) is ignored and has no effect on the operation in flight.
- start high in the same cycle done is high (state IDLE) is accepted: back-to-back operation with no gap.
- Operands are not required to stay stable after the start edge.
- Reset asserted mid-operation aborts immediately to reset values; no done is produced.

Test Plan:
- 11070 / 90 (W=8) -> at E+17: quotient=123, remainder=0, done pulse=1 cycle, flags 0; busy high E+1..E+16.
- -11070 / 90 -> quotient=-123 (8'h85), remainder=0. Also 1000 / -9 -> quotient=-111, remainder=1. Also -1000 / 9 -> quotient=-111, remainder=-1 (8'hFF).
- Overflow cases:
  - 32767 / 1 -> quotient=127, overflow=1.
  - -128 / -1 -> quotient=127, overflow=1.
  - -32768 / 1 -> quotient=-128, overflow=1.
  - 128 / -1 -> quotient=-128, overflow=0.
  - -32768 / -128 -> quotient=127 (true 256), overflow=1, remainder=0.
- 500 / 0 -> at E+17: div_by_zero=1, quotient=0, remainder=0, overflow=0.
- Handshake:
  - start pulsed again at E+5 with different operands -> ignored; the first result is unchanged at E+17.
  - start held high through the done cycle -> second op accepted at E+17, second done at E+34.
- Reset:
  - rst_n low at E+8 -> all outputs 0, no done.
  - A new start after release completes normally with latency 2W+1.

Source files
------------

// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Magnitude shift-subtract core, one quotient bit per cycle, start/busy/done handshake.
module booth_divider #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(2*W);
    localparam logic [2*W-1:0] MAG_NEG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] MAG_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_n_q, sign_n_d;
    logic            sign_d_q, sign_d_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [2*W-1:0]  quo_q, quo_d;
    logic [W-1:0]    quotient_q, quotient_d;
    logic [W-1:0]    remainder_q, remainder_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [W:0]      rem_shift;
    logic            rem_ge;
    logic            q_neg;
    logic            q_ovf;
    logic [W-1:0]    q_low;
    logic [W-1:0]    r_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sign_n_q    <= 1'b0;
            sign_d_q    <= 1'b0;
            dz_q        <= 1'b0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_n_q    <= sign_n_d;
            sign_d_q    <= sign_d_d;
            dz_q        <= dz_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // quo_q starts holding |dividend| and is shifted out MSB-first while quotient bits
    // fill in from the LSB; rem_q stays below |divisor| <= 2^(W-1), so W bits suffice.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_n_d    = sign_n_q;
        sign_d_d    = sign_d_q;
        dz_d        = dz_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        rem_shift = {rem_q, quo_q[2*W-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        q_neg     = sign_n_q ^ sign_d_q;
        q_ovf     = q_neg ? (quo_q > MAG_NEG) : (quo_q > MAG_POS);
        q_low     = q_neg ? -quo_q[W-1:0] : quo_q[W-1:0];
        r_signed  = sign_n_q ? -rem_q : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_n_d = dividend[2*W-1];
                    sign_d_d = divisor[W-1];
                    quo_d    = dividend[2*W-1] ? -dividend : dividend;
                    dvs_d    = divisor[W-1] ? -divisor : divisor;
                    dz_d     = (divisor == '0);
                    rem_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ITER;
                end
            end
            ITER: begin
                if (rem_ge) begin
                    rem_d = rem_shift[W-1:0] - dvs_q;
                end else begin
                    rem_d = rem_shift[W-1:0];
                end
                quo_d = {quo_q[2*W-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2*W-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
                    dbz_d       = 1'b0;
                    ovf_d       = q_ovf;
                    remainder_d = r_signed;
                    if (q_ovf) begin
                        quotient_d = q_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    end else begin
                        quotient_d = q_low;
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
